// File: rtl/updown_counter_if.sv
// -----------------------------------------------------------------------------
// updown_counter_if
//
// Purpose: groups the control, configuration and status signals of
// updown_counter so that a controller and the counter connect through a single
// bundle. The clock and the reset are not part of the bundle.
//
// Parameter:
//   Size       counter width in bits; must match the counter's Size.
//
// Signals:
//   enable     count one step this cycle            (master -> slave)
//   up         1 = increment, 0 = decrement         (master -> slave)
//   load       synchronous load of loadValue        (master -> slave)
//   loadValue  value to load, clamped to limit      (master -> slave)
//   clear      synchronous clear of count/overflow  (master -> slave)
//   limit      inclusive upper bound of the range   (master -> slave)
//   count      current count                        (slave -> master)
//   terminal   one-cycle boundary-event pulse       (slave -> master)
//   overflow   sticky boundary-event flag           (slave -> master)
// -----------------------------------------------------------------------------
interface updown_counter_if #(
    parameter int Size = 5
) ();

    logic            enable;
    logic            up;
    logic            load;
    logic [Size-1:0] loadValue;
    logic            clear;
    logic [Size-1:0] limit;
    logic [Size-1:0] count;
    logic            terminal;
    logic            overflow;

    // Controller side: drives commands, observes status.
    modport master (
        output enable,
        output up,
        output load,
        output loadValue,
        output clear,
        output limit,
        input  count,
        input  terminal,
        input  overflow
    );

    // Counter side: observes commands, drives status.
    modport slave (
        input  enable,
        input  up,
        input  load,
        input  loadValue,
        input  clear,
        input  limit,
        output count,
        output terminal,
        output overflow
    );

endinterface

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//
// Purpose: up/down, loadable counter with a programmable inclusive limit and a
// choice of overflow policy (wrap or saturate). Counting primitive for timers,
// prescalers and bounded pointers. Every output is registered, so there is no
// combinational path from any input to any output.
//
// Parameters:
//   Size        counter width in bits (>= 2)
//   Saturate    0 = wrap at the bounds, 1 = hold at the bounds
//   ResetValue  count value while reset is asserted (<= 2^Size-1)
//
// Ports:
//   clock       rising-edge clock, the only clock
//   reset       asynchronous, active-low reset
//   ctr         updown_counter_if slave modport:
//                 enable/up/load/loadValue/clear/limit in,
//                 count/terminal/overflow out
//
// Per-edge priority is clear > load > enable; at most one action applies.
// A boundary event (stepping past limit going up, or past 0 going down)
// raises terminal for one cycle and sets the sticky overflow flag.
// -----------------------------------------------------------------------------
module updown_counter #(
    parameter int              Size       = 5,
    parameter bit              Saturate   = 1'b0,
    parameter logic [Size-1:0] ResetValue = '0
) (
    input  logic          clock,
    input  logic          reset,
    updown_counter_if.slave ctr
);

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Unsigned minimum; used to keep loaded values inside 0..limit.
    function automatic logic [Size-1:0] f_clamp(
        input logic [Size-1:0] value,
        input logic [Size-1:0] lim
    );
        return (value > lim) ? lim : value;
    endfunction

    // Value taken after an upward boundary event.
    function automatic logic [Size-1:0] f_up_bound(
        input logic [Size-1:0] lim
    );
        return Saturate ? lim : '0;
    endfunction

    // Value taken after a downward boundary event.
    function automatic logic [Size-1:0] f_down_bound(
        input logic [Size-1:0] lim
    );
        return Saturate ? '0 : lim;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [Size-1:0] r_count;
    logic            r_terminal;
    logic            r_overflow;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [Size-1:0] w_next_count;
    logic            w_event;
    logic            w_next_overflow;
    logic            w_count_at_top;
    logic            w_count_zero;
    logic            w_count_above;

    // Comparisons are all unsigned over Size bits. "At top" covers counts that
    // are above limit too, so a lowered limit followed by an up step is treated
    // as a boundary event rather than an increment past the bound.
    assign w_count_at_top = (r_count >= ctr.limit);
    assign w_count_zero   = (r_count == '0);
    assign w_count_above  = (r_count >  ctr.limit);

    always_comb begin
        w_next_count    = r_count;
        w_event         = 1'b0;
        w_next_overflow = r_overflow;

        if (ctr.clear) begin
            w_next_count    = '0;
            w_next_overflow = 1'b0;
        end else if (ctr.load) begin
            w_next_count = f_clamp(ctr.loadValue, ctr.limit);
        end else if (ctr.enable) begin
            if (ctr.up) begin
                if (w_count_at_top) begin
                    w_event      = 1'b1;
                    w_next_count = f_up_bound(ctr.limit);
                end else begin
                    w_next_count = r_count + 1'b1;
                end
            end else begin
                if (w_count_zero) begin
                    // With limit = 0 this also pins the count at 0.
                    w_event      = 1'b1;
                    w_next_count = f_down_bound(ctr.limit);
                end else if (w_count_above) begin
                    // Limit was lowered under a live count: snap to the new
                    // bound without reporting an event.
                    w_next_count = ctr.limit;
                end else begin
                    w_next_count = r_count - 1'b1;
                end
            end
        end

        if (w_event) begin
            w_next_overflow = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= ResetValue;
            r_terminal <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_terminal <= w_event;
            r_overflow <= w_next_overflow;
        end
    end

    assign ctr.count    = r_count;
    assign ctr.terminal = r_terminal;
    assign ctr.overflow = r_overflow;

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised, up/down, loadable counter with a programmable limit and two overflow policies: wrap or saturate. It generalises the single-mode free-running counter. It is the counting primitive for timers, prescalers and bounded pointers, and it is exercised through the same Ruby-driven bench flow as the rest of the samples. All outputs are registered, so downstream logic and the bench sample them one step after the clock edge.

## Interface
Parameters:
- Size, 5, counter width in bits (≥ 2).
- Saturate, 0, overflow policy: 0 = wrap, 1 = saturate.
- ResetValue, 0, value loaded into count on reset (must be ≤ 2^Size−1).

Ports:
- clock  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count one step this cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load of loadValue.
- loadValue  input  Size  value to load.
- clear  input  1  synchronous clear of count and overflow.
- limit  input  Size  upper bound; the legal range is 0..limit inclusive.
- count  output  Size  current count.
- terminal  output  1  one-cycle pulse: a boundary event occurred on the previous edge.
- overflow  output  1  sticky flag: at least one boundary event since the last reset or clear.

## Operation
- Priority per edge: clear > load > enable. At most one action applies.
- clear: count ← 0, overflow ← 0, terminal ← 0.
- load: count ← min(loadValue, limit); terminal ← 0; overflow unchanged.
- enable with up=1:
  - if count < limit: count ← count+1.
  - else (count ≥ limit): boundary event. Wrap mode: count ← 0. Saturate mode: count ← limit.
- enable with up=0:
  - if count > 0 and count ≤ limit: count ← count−1.
  - if count > limit (limit lowered under a live count): count ← limit, no event.
  - if count = 0: boundary event. Wrap mode: count ← limit. Saturate mode: count stays 0.
- Boundary event: terminal ← 1 for that edge only, and overflow ← 1. A saturate-mode event fires every enabled edge while the count is held at the bound.
- No action (enable=0, no load, no clear): count holds, terminal ← 0.
- limit = 0: the count is pinned to 0, and every enabled step is a boundary event.
- All comparisons are unsigned over Size bits. No arithmetic carries past Size bits.
- Inputs other than reset are sampled only at the rising clock edge.

## Timing
- Reset asserted (reset=0): immediately, with no clock needed, count = ResetValue, terminal = 0, overflow = 0. These values hold while reset is low.
- First action after reset occurs on the first rising edge with reset=1. Deassertion must meet recovery time relative to clock.
- Reset mid-count overrides everything, including a pending load or clear.
- Latency: one edge from the input to count, terminal and overflow. No combinational input-to-output paths.
- terminal is high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Changing limit takes effect on the next edge and is not itself an event.

## Test plan
Use Size=5 throughout. Drive inputs 1 time unit after the rising edge and sample before the next edge.
- Reset: assert reset=0 mid-cycle with count=17 (ResetValue=3) -> count=3, terminal=0, overflow=0 at once, before any edge.
- Wrap up: Saturate=0, limit=9, up=1, enable=1 from 0 for 12 edges -> count 1..9, then 0, 1, 2. terminal is high in the single cycle where count=0. overflow=1 from then on.
- Wrap down and saturate:
  - Saturate=0, limit=9, up=0 from 0 -> count=9, terminal pulse.
  - Saturate=1, up=1 from 8 for 4 edges -> 9, 9, 9, 9, with terminal high on edges 2–4.
- Priority: clear=1, load=1 (loadValue=5) and enable=1 on one edge -> count=0, overflow=0. Next edge with load=1 only -> count=5.
- Load clamp and limit change:
  - load loadValue=31 with limit=20 -> count=20.
  - Then limit=10, up=0, enable -> count=10, terminal=0.
  - Then up=1 -> count=0 (wrap mode), terminal=1.
- Full range: limit=31, wrap mode, 64 up edges from 0 -> exactly two terminal pulses, count back to 0. Then 64 down edges -> two pulses, count=0.
